// File: rtl/rv32_pkg.sv
// Shared RV32 register-file types: data/index widths and the writeback entry
// that travels from the ALU FIFO to the regi write port.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO; head is visible on dout whenever not empty.
// Push when full and pop when empty are ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, rptr;
    logic                    do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller for regi: loads take the port first, ALU results queue
// in a FIFO, x0 writes are dropped, and a pending-write scoreboard feeds decode.
module rf_wb_ctrl
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [AW-1:0]          rd,
    output logic                   we,
    output logic [XLEN-1:0]        indata,
    output logic [$clog2(DEPTH):0] fifo_count
);
    wb_entry           head, sel;
    logic              full, empty, push, pop, sel_vld;
    logic [NREG-1:0]   busy, set_mask, clr_mask;

    assign alu_ready = !full;
    assign push      = alu_valid && alu_ready;
    assign pop       = !ld_valid && !empty;

    wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({alu_rd, alu_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign sel_vld = ld_valid || pop;
    assign sel     = ld_valid ? wb_entry'{rd: ld_rd, data: ld_data} : head;

    // x0 entries still advance rd/indata, but never raise we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd     <= '0;
            we     <= 1'b0;
            indata <= '0;
        end else if (sel_vld) begin
            rd     <= sel.rd;
            we     <= (sel.rd != '0);
            indata <= sel.data;
        end else begin
            we     <= 1'b0;
        end
    end

    // Clear tracks the write regi captures this edge; a same-edge issue re-sets.
    assign clr_mask = we ? (NREG'(1) << rd) : '0;
    assign set_mask = (issue_valid && issue_rd != '0) ? (NREG'(1) << issue_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl with a behavioural regi array on the write port.
module tb_rf_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] indata;
    logic [2:0]  fifo_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] regi [32];

    always #5 clk = ~clk;

    rf_wb_ctrl #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd          (rd),
        .we          (we),
        .indata      (indata),
        .fifo_count  (fifo_count)
    );

    // Plain array model of regi: no x0 hardwiring, so a stray x0 write shows up.
    always @(posedge clk) begin
        if (we) regi[rd] <= indata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regi[i] = '0;
        rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 5'd1; rs2 = 5'd0;
        #3;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_indata", indata, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_busy", {31'd0, rs1_busy}, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Single ALU write to x1
        step();
        issue_valid = 1; issue_rd = 5'd1;
        step();
        issue_valid = 0;
        chk("t1_busy_set", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h9;
        step();
        alu_valid = 0;
        chk("t1_count", {29'd0, fifo_count}, 32'd1);
        chk("t1_we_early", {31'd0, we}, 32'd0);
        step();
        chk("t1_we", {31'd0, we}, 32'd1);
        chk("t1_rd", {27'd0, rd}, 32'd1);
        chk("t1_indata", indata, 32'h9);
        chk("t1_busy_hold", {31'd0, rs1_busy}, 32'd1);
        step();
        chk("t1_regi", regi[1], 32'h9);
        chk("t1_busy_clr", {31'd0, rs1_busy}, 32'd0);
        chk("t1_we_off", {31'd0, we}, 32'd0);

        // Load priority over a same-edge ALU push
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hA;
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'hB;
        step();
        alu_valid = 0; ld_valid = 0;
        chk("t2_ld_rd", {27'd0, rd}, 32'd3);
        chk("t2_ld_data", indata, 32'hB);
        chk("t2_ld_we", {31'd0, we}, 32'd1);
        chk("t2_count1", {29'd0, fifo_count}, 32'd1);
        step();
        chk("t2_alu_rd", {27'd0, rd}, 32'd2);
        chk("t2_alu_data", indata, 32'hA);
        chk("t2_alu_we", {31'd0, we}, 32'd1);
        chk("t2_count0", {29'd0, fifo_count}, 32'd0);
        step();
        chk("t2_regi3", regi[3], 32'hB);
        chk("t2_regi2", regi[2], 32'hA);

        // FIFO fills behind a held load, then drains in order
        ld_valid = 1; ld_rd = 5'd5; ld_data = 32'h55;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(5 + i); alu_data = 32'(i);
            step();
        end
        chk("t3_full_cnt", {29'd0, fifo_count}, 32'd4);
        chk("t3_full_rdy", {31'd0, alu_ready}, 32'd0);
        chk("t3_ld_data", indata, 32'h55);
        alu_rd = 5'd10; alu_data = 32'h5;
        step();
        chk("t3_held_cnt", {29'd0, fifo_count}, 32'd4);
        ld_valid = 0;
        step();
        chk("t3_d1", indata, 32'h1);
        chk("t3_d1_cnt", {29'd0, fifo_count}, 32'd3);
        chk("t3_d1_rdy", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 0;
        chk("t3_d2", indata, 32'h2);
        chk("t3_d2_cnt", {29'd0, fifo_count}, 32'd3);
        for (int i = 3; i <= 5; i++) begin
            step();
            chk("t3_dn", indata, 32'(i));
            chk("t3_dn_we", {31'd0, we}, 32'd1);
        end
        chk("t3_empty", {29'd0, fifo_count}, 32'd0);
        step();
        chk("t3_idle_we", {31'd0, we}, 32'd0);

        // x0 suppression
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        issue_valid = 1; issue_rd = 5'd0; rs1 = 5'd0;
        step();
        alu_valid = 0; issue_valid = 0;
        chk("t4_cnt", {29'd0, fifo_count}, 32'd1);
        chk("t4_busy0", {31'd0, rs1_busy}, 32'd0);
        step();
        chk("t4_popped", {29'd0, fifo_count}, 32'd0);
        chk("t4_we", {31'd0, we}, 32'd0);
        step();
        chk("t4_regi0", regi[0], 32'd0);

        // Scoreboard set wins over a same-edge clear
        rs2 = 5'd4;
        issue_valid = 1; issue_rd = 5'd4;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
        step();
        issue_valid = 0; alu_valid = 0;
        chk("t5_busy_set", {31'd0, rs2_busy}, 32'd1);
        step();
        chk("t5_we4", {31'd0, we}, 32'd1);
        chk("t5_rd4", {27'd0, rd}, 32'd4);
        issue_valid = 1; issue_rd = 5'd4;
        step();
        issue_valid = 0;
        chk("t5_collide", {31'd0, rs2_busy}, 32'd1);
        chk("t5_regi4", regi[4], 32'h44);
        step();
        chk("t5_still", {31'd0, rs2_busy}, 32'd1);

        // Async reset with three queued entries
        rs1 = 5'd7;
        issue_valid = 1; issue_rd = 5'd7;
        ld_valid = 1; ld_rd = 5'd8; ld_data = 32'h88;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(11 + i); alu_data = 32'(32'hB0 + i);
            step();
            issue_valid = 0;
        end
        chk("t6_cnt3", {29'd0, fifo_count}, 32'd3);
        chk("t6_busy7", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 0; ld_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", {29'd0, fifo_count}, 32'd0);
        chk("t6_rst_we", {31'd0, we}, 32'd0);
        chk("t6_rst_b7", {31'd0, rs1_busy}, 32'd0);
        chk("t6_rst_b4", {31'd0, rs2_busy}, 32'd0);
        chk("t6_rst_rdy", {31'd0, alu_ready}, 32'd1);
        #2 rst_n = 1'b1;
        step();
        chk("t6_nostale1", {31'd0, we}, 32'd0);
        step();
        chk("t6_nostale2", {31'd0, we}, 32'd0);
        chk("t6_cnt_after", {29'd0, fifo_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
